gb80_sequencer: RTL

GB80_SEQUENCER -- requirements
Module: gb80_sequencer

---
 rtl/gb80_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/gb80_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gb80_sequencer
// Brief    : Three-cycle IDLE/EXEC/WB instruction sequencer with an 8080-style
//            ALU and flag register, plus a HALT state left by a wake pulse.
// Revision : 1.0 - initial release
// ============================================================================
module gb80_sequencer #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 3,
    parameter int OPCODE_TYPE_LENGTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [OPCODE_TYPE_LENGTH-1:0] i_opcode_type,
    input  logic [DATA_WIDTH-1:0]         i_literal_value,
    input  logic [ADDR_WIDTH-1:0]         i_addr_A,
    input  logic [ADDR_WIDTH-1:0]         i_addr_B,
    input  logic                          i_decode_valid,
    output logic                          o_decode_ready,
    output logic [ADDR_WIDTH-1:0]         o_rf_raddr_A,
    output logic [ADDR_WIDTH-1:0]         o_rf_raddr_B,
    input  logic [DATA_WIDTH-1:0]         i_rf_rdata_A,
    input  logic [DATA_WIDTH-1:0]         i_rf_rdata_B,
    output logic                          o_rf_we,
    output logic [ADDR_WIDTH-1:0]         o_rf_waddr,
    output logic [DATA_WIDTH-1:0]         o_rf_wdata,
    output logic [3:0]                    o_flags,
    input  logic                          i_wake,
    output logic                          o_halted,
    output logic                          o_illegal
);

    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_nop   = OPCODE_TYPE_LENGTH'(0);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_ld_rr = OPCODE_TYPE_LENGTH'(1);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_ld_li = OPCODE_TYPE_LENGTH'(2);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_add   = OPCODE_TYPE_LENGTH'(3);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_sub   = OPCODE_TYPE_LENGTH'(4);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_and   = OPCODE_TYPE_LENGTH'(5);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_or    = OPCODE_TYPE_LENGTH'(6);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_xor   = OPCODE_TYPE_LENGTH'(7);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_inc   = OPCODE_TYPE_LENGTH'(8);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_dec   = OPCODE_TYPE_LENGTH'(9);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_cp    = OPCODE_TYPE_LENGTH'(10);
    localparam logic [OPCODE_TYPE_LENGTH-1:0] c_op_halt  = OPCODE_TYPE_LENGTH'(11);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_accept;

    logic [OPCODE_TYPE_LENGTH-1:0] r_type;
    logic [DATA_WIDTH-1:0]         r_literal;
    logic [ADDR_WIDTH-1:0]         r_addr_a;
    logic [ADDR_WIDTH-1:0]         r_addr_b;
    logic [DATA_WIDTH-1:0]         r_result;
    logic [3:0]                    r_next_flags;
    logic [3:0]                    r_flags;

    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [3:0]            w_alu_flags;
    logic                  w_alu_sets_flags;
    logic                  w_n;
    logic                  w_h;
    logic                  w_c;
    logic                  w_write_type;
    logic                  w_illegal_type;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_decode_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = (r_type == c_op_halt) ? S_HALT : S_IDLE;
            S_HALT:  w_next_state = i_wake ? S_IDLE : S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Carry/borrow are derived by comparison so no partial sum bits dangle.
    always_comb begin
        w_alu_result     = r_result;
        w_alu_sets_flags = 1'b0;
        w_n              = 1'b0;
        w_h              = 1'b0;
        w_c              = 1'b0;
        case (r_type)
            c_op_ld_rr: w_alu_result = i_rf_rdata_B;
            c_op_ld_li: w_alu_result = r_literal;
            c_op_add: begin
                w_alu_result     = i_rf_rdata_A + i_rf_rdata_B;
                w_alu_sets_flags = 1'b1;
                w_h              = i_rf_rdata_A[3:0] > ~i_rf_rdata_B[3:0];
                w_c              = i_rf_rdata_A > ~i_rf_rdata_B;
            end
            c_op_sub, c_op_cp: begin
                w_alu_result     = i_rf_rdata_A - i_rf_rdata_B;
                w_alu_sets_flags = 1'b1;
                w_n              = 1'b1;
                w_h              = i_rf_rdata_A[3:0] < i_rf_rdata_B[3:0];
                w_c              = i_rf_rdata_A < i_rf_rdata_B;
            end
            c_op_and: begin
                w_alu_result     = i_rf_rdata_A & i_rf_rdata_B;
                w_alu_sets_flags = 1'b1;
                w_h              = 1'b1;
            end
            c_op_or: begin
                w_alu_result     = i_rf_rdata_A | i_rf_rdata_B;
                w_alu_sets_flags = 1'b1;
            end
            c_op_xor: begin
                w_alu_result     = i_rf_rdata_A ^ i_rf_rdata_B;
                w_alu_sets_flags = 1'b1;
            end
            c_op_inc: begin
                w_alu_result     = i_rf_rdata_A + DATA_WIDTH'(1);
                w_alu_sets_flags = 1'b1;
                w_h              = i_rf_rdata_A[3:0] == 4'hF;
                w_c              = r_flags[0];
            end
            c_op_dec: begin
                w_alu_result     = i_rf_rdata_A - DATA_WIDTH'(1);
                w_alu_sets_flags = 1'b1;
                w_n              = 1'b1;
                w_h              = i_rf_rdata_A[3:0] == 4'h0;
                w_c              = r_flags[0];
            end
            default: w_alu_result = r_result;
        endcase
        w_alu_flags = w_alu_sets_flags ? {(w_alu_result == '0), w_n, w_h, w_c} : r_flags;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_type       <= c_op_nop;
            r_literal    <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_result     <= '0;
            r_next_flags <= 4'b0000;
            r_flags      <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_type    <= i_opcode_type;
                r_literal <= i_literal_value;
                r_addr_a  <= i_addr_A;
                r_addr_b  <= i_addr_B;
            end
            if (r_state == S_EXEC) begin
                r_result     <= w_alu_result;
                r_next_flags <= w_alu_flags;
            end
            if (r_state == S_WB) begin
                r_flags <= r_next_flags;
            end
        end
    end

    assign w_write_type   = (r_type >= c_op_ld_rr) && (r_type <= c_op_dec);
    assign w_illegal_type = r_type > c_op_halt;

    // Write strobe is masked by reset so an aborted WB never reaches the file.
    assign o_rf_we        = (r_state == S_WB) && w_write_type && !i_reset;
    assign o_illegal      = (r_state == S_WB) && w_illegal_type && !i_reset;
    assign o_rf_waddr     = r_addr_a;
    assign o_rf_wdata     = r_result;
    assign o_rf_raddr_A   = r_addr_a;
    assign o_rf_raddr_B   = r_addr_b;
    assign o_flags        = r_flags;
    assign o_decode_ready = (r_state == S_IDLE);
    assign o_halted       = (r_state == S_HALT);

endmodule
`default_nettype wire
